// File: rtl/exec_sequencer.sv
// Run-control sequencer: synchronizes the front-panel keys, owns pc/eom and
// arbitrates the instruction-memory port between DIP-switch loading and fetch.
module exec_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_load,
    input  logic              key_run,
    input  logic              key_step,
    input  logic              key_clear,
    input  logic [DATA_W-1:0] load_data,
    input  logic              branch,
    input  logic              taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] im_addr,
    output logic              im_we,
    output logic [DATA_W-1:0] im_din,
    output logic              ir_load,
    output logic              exec_en,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] eom,
    output logic              running,
    output logic              halted,
    output logic              load_full
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [ADDR_W-1:0] EOM_MAX = '1;

    // Key bit order everywhere: {clear, load, run, step}
    logic [3:0] key_raw;
    logic [3:0] sync_p0;
    logic [3:0] sync_p1;
    logic [3:0] hist_p2;
    logic [3:0] edge_q;

    logic clear_e;
    logic load_e;
    logic run_e;
    logic step_e;

    logic [2:0]      state;
    logic            pause_pend;
    logic [ADDR_W:0] next_pc;
    logic            pc_lt_eom;

    assign key_raw = {key_clear, key_load, key_run, key_step};

    // Stage boundary: two synchronizer flops, history flop, registered rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            hist_p2 <= '0;
            edge_q  <= '0;
        end else begin
            sync_p0 <= key_raw;
            sync_p1 <= sync_p0;
            hist_p2 <= sync_p1;
            edge_q  <= sync_p1 & ~hist_p2;
        end
    end

    assign clear_e = edge_q[3];
    assign load_e  = edge_q[2] & ~edge_q[3];
    assign run_e   = edge_q[1] & ~(|edge_q[3:2]);
    assign step_e  = edge_q[0] & ~(|edge_q[3:1]);

    // One bit wider so a jump/increment past the last address still halts
    assign next_pc   = (branch && taken) ? {1'b0, branch_target}
                                         : {1'b0, pc} + (ADDR_W + 1)'(1);
    assign pc_lt_eom = (pc < eom);
    assign load_full = (eom == EOM_MAX);
    assign halted    = (state == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            eom        <= '0;
            running    <= 1'b0;
            pause_pend <= 1'b0;
        end else if (clear_e) begin
            state      <= S_IDLE;
            pc         <= '0;
            eom        <= '0;
            running    <= 1'b0;
            pause_pend <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_e) begin
                        state <= S_LOAD;
                    end else if ((run_e || step_e) && pc_lt_eom) begin
                        state   <= S_FETCH;
                        running <= run_e;
                    end
                end
                S_LOAD: begin
                    if (!load_full) begin
                        eom <= eom + ADDR_W'(1);
                    end
                    state <= S_IDLE;
                end
                S_FETCH: begin
                    pause_pend <= pause_pend | (running & run_e);
                    state      <= S_DECODE;
                end
                S_DECODE: begin
                    pause_pend <= pause_pend | (running & run_e);
                    state      <= S_EXEC;
                end
                S_EXEC: begin
                    pc         <= next_pc[ADDR_W-1:0];
                    pause_pend <= 1'b0;
                    if (next_pc >= {1'b0, eom}) begin
                        state   <= S_HALT;
                        running <= 1'b0;
                    end else if (running && !run_e && !pause_pend) begin
                        state <= S_FETCH;
                    end else begin
                        state   <= S_IDLE;
                        running <= 1'b0;
                    end
                end
                S_HALT: begin
                    if (run_e) begin
                        pc      <= '0;
                        state   <= S_FETCH;
                        running <= 1'b1;
                    end else if (load_e) begin
                        state <= S_LOAD;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Port outputs decode from state so an async reset clears them immediately
    always_comb begin
        im_addr = pc;
        im_we   = 1'b0;
        im_din  = '0;
        ir_load = 1'b0;
        exec_en = 1'b0;
        case (state)
            S_LOAD: begin
                im_addr = eom;
                im_we   = ~load_full;
                im_din  = load_data;
            end
            S_DECODE: ir_load = 1'b1;
            S_EXEC:   exec_en = 1'b1;
            default: ;
        endcase
    end

endmodule
